// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply waits MUL_LAT cycles; divide is restoring, one bit per cycle, then a sign-fix cycle.
module muldiv_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
   localparam int CW      = $clog2(CNT_MAX);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     trial;
   logic               a_neg;
   logic               b_neg;

   // Sign-extend captured operands and form the full-width product
   always_comb begin
      ext_a = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
      ext_b = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
      prod  = ext_a * ext_b;
   end

   // One restoring-divide step: shift in next dividend bit, trial subtract
   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, opb_q};
   end

   // Operand signs seen at issue, only meaningful for signed divide
   always_comb begin
      a_neg = (op == OP_DIV) & a[WIDTH-1];
      b_neg = (op == OP_DIV) & b[WIDTH-1];
   end

   // Next-state logic for the control FSM and datapath registers
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sgn_d   = sgn_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     opa_d   = a;
                     opb_d   = b;
                     sgn_d   = (op == OP_MULT);
                     cnt_d   = CW'(MUL_LAT - 1);
                     state_d = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     opa_d   = a;
                     quo_d   = a_neg ? -a : a;
                     opb_d   = b_neg ? -b : b;
                     rem_d   = '0;
                     negq_d  = a_neg ^ b_neg;
                     negr_d  = a_neg;
                     dz_d    = (b == '0);
                     cnt_d   = CW'(WIDTH - 1);
                     state_d = S_DIV;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (!trial[WIDTH]) begin
                  rem_d = trial[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (dz_q) begin
                  hi_d = opa_q;
                  lo_d = '1;
               end else begin
                  hi_d = negr_q ? -rem_q : rem_q;
                  lo_d = negq_q ? -quo_q : quo_q;
               end
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         sgn_q   <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sgn_q   <= sgn_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
